vx_csr_access_ctrl: RTL and testbench

VX_CSR_ACCESS_CTRL -- requirements
Module: VX_csr_access_ctrl

---
 rtl/vx_csr_access_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_vx_csr_access_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// vx_csr_access_ctrl
//
// CSR read-modify-write controller for one issue slot. A request is accepted,
// the CSR is read combinationally in the same cycle, and the old and new
// values are captured into a single stage. The new value is written back one
// cycle later (WRITE state). The old value is returned to the destination
// register through a valid/ready response. The response is held in the HOLD
// state while the consumer stalls.
//
// Handshake semantics (both request and response sides):
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   ready may depend combinationally on the partner's signals.
//   - req_ready depends on rsp_ready and on the request fields (hazard check).
//   - While rsp_valid & ~rsp_ready, every rsp_* field is held stable.
//
// Optional feature (macro VX_CSR_RAW_BYPASS_EN):
//   undefined (default): any read-after-write hazard on the in-flight write
//                        stalls the request until the write has retired.
//   defined            : an exact (addr, wid) match is resolved by forwarding
//                        the pending new value as the old value. Matches that
//                        exist only through the fflags/frm/fcsr alias group
//                        still stall.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   req_*               request: op (0=RW,1=RS,2=RC,3=read-only), addr,
//                       wid, uuid, rd, immediate / rs1 source operand
//   read_*              CSR read port; read_data returns in the same cycle
//   write_*             CSR write port; storage samples it on the clk edge
//   rsp_*               writeback response carrying the old CSR value
//   busy                request pending or stage 1 occupied
//   dbg_state           stage-1 state: 0=IDLE, 1=WRITE, 2=HOLD
// ---------------------------------------------------------------------------
module vx_csr_access_ctrl #(
    parameter int CSR_ADDR_BITS = 12,
    parameter int NW_BITS       = 2,
    parameter int UUID_BITS     = 44,
    parameter int RD_BITS       = 5
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [CSR_ADDR_BITS-1:0] req_addr,
    input  logic [NW_BITS-1:0]       req_wid,
    input  logic [UUID_BITS-1:0]     req_uuid,
    input  logic [RD_BITS-1:0]       req_rd,
    input  logic                     req_use_imm,
    input  logic [4:0]               req_imm,
    input  logic [31:0]              req_rs1_data,

    output logic                     read_enable,
    output logic [CSR_ADDR_BITS-1:0] read_addr,
    output logic [NW_BITS-1:0]       read_wid,
    output logic [UUID_BITS-1:0]     read_uuid,
    input  logic [31:0]              read_data,

    output logic                     write_enable,
    output logic [CSR_ADDR_BITS-1:0] write_addr,
    output logic [NW_BITS-1:0]       write_wid,
    output logic [UUID_BITS-1:0]     write_uuid,
    output logic [31:0]              write_data,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RD_BITS-1:0]       rsp_rd,
    output logic [NW_BITS-1:0]       rsp_wid,
    output logic [UUID_BITS-1:0]     rsp_uuid,
    output logic [31:0]              rsp_data,

    output logic                     busy,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [1:0] OP_RW = 2'd0;
    localparam logic [1:0] OP_RS = 2'd1;
    localparam logic [1:0] OP_RC = 2'd2;

    state_e state_q, state_d;

    // Stage-1 captured instruction (no reset needed: only observed while
    // the state machine says the stage is occupied).
    logic [RD_BITS-1:0]       rd_q;
    logic [NW_BITS-1:0]       wid_q;
    logic [UUID_BITS-1:0]     uuid_q;
    logic [CSR_ADDR_BITS-1:0] addr_q;
    logic [31:0]              old_q;
    logic [31:0]              new_q;
    logic                     wen_q;

    logic [31:0] src_val;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        wen_val;
    logic        accept;
    logic        pend_write;
    logic        exact_match;
    logic        alias_match;
    logic        stall;

    // fflags (0x001), frm (0x002) and fcsr (0x003) are views of the same
    // underlying state, so any two of them conflict.
    function automatic logic is_fp_csr(input logic [CSR_ADDR_BITS-1:0] a);
        return (a == CSR_ADDR_BITS'(1)) || (a == CSR_ADDR_BITS'(2)) ||
               (a == CSR_ADDR_BITS'(3));
    endfunction

    assign src_val = req_use_imm ? {27'd0, req_imm} : req_rs1_data;

    // Only a write that will actually be issued this cycle can conflict.
    assign pend_write  = (state_q == ST_WRITE) && wen_q;
    assign exact_match = pend_write && (req_wid == wid_q) && (req_addr == addr_q);
    assign alias_match = pend_write && (req_wid == wid_q) &&
                         is_fp_csr(req_addr) && is_fp_csr(addr_q);

`ifdef VX_CSR_RAW_BYPASS_EN
    assign stall   = alias_match && !exact_match;
    assign old_val = exact_match ? new_q : read_data;
`else
    assign stall   = exact_match || alias_match;
    assign old_val = read_data;
`endif

    assign req_ready = ((state_q == ST_IDLE) || rsp_ready) && !stall;
    assign accept    = req_valid && req_ready;

    assign read_enable = accept;
    assign read_addr   = req_addr;
    assign read_wid    = req_wid;
    assign read_uuid   = req_uuid;

    // Set/clear with a zero operand is a pure read and must not write.
    always_comb begin
        new_val = old_val;
        wen_val = 1'b0;
        case (req_op)
            OP_RW: begin
                new_val = src_val;
                wen_val = 1'b1;
            end
            OP_RS: begin
                new_val = old_val | src_val;
                wen_val = (src_val != 32'd0);
            end
            OP_RC: begin
                new_val = old_val & ~src_val;
                wen_val = (src_val != 32'd0);
            end
            default: begin
                new_val = old_val;
                wen_val = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q   <= req_rd;
            wid_q  <= req_wid;
            uuid_q <= req_uuid;
            addr_q <= req_addr;
            old_q  <= old_val;
            new_q  <= new_val;
            wen_q  <= wen_val;
        end
    end

    always_comb begin
        state_d      = state_q;
        rsp_valid    = 1'b0;
        write_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_WRITE;
            end
            ST_WRITE, ST_HOLD: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = accept ? ST_WRITE : ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // The write fires only on the first cycle in stage 1; a reset in
        // that cycle abandons the instruction before it touches the CSR.
        if ((state_q == ST_WRITE) && wen_q && !reset) begin
            write_enable = 1'b1;
        end
    end

    assign write_addr = addr_q;
    assign write_wid  = wid_q;
    assign write_uuid = uuid_q;
    assign write_data = new_q;

    assign rsp_rd   = rd_q;
    assign rsp_wid  = wid_q;
    assign rsp_uuid = uuid_q;
    assign rsp_data = old_q;

    assign busy      = req_valid || (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vx_csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vx_csr_access_ctrl
//
// The bench owns the CSR storage array that the DUT reads and writes. The
// reference model executes every accepted instruction in program order
// against its own copy of the CSR array. This yields the expected response
// (old value) and the expected write for each instruction. Directed steps
// cover the documented scenarios; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_vx_csr_access_ctrl;

    localparam int AW = 12;
    localparam int NW = 2;
    localparam int UW = 44;
    localparam int RB = 5;

`ifdef VX_CSR_RAW_BYPASS_EN
    localparam int EXP_RAW_STALL = 0;
`else
    localparam int EXP_RAW_STALL = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [NW-1:0] req_wid;
    logic [UW-1:0] req_uuid;
    logic [RB-1:0] req_rd;
    logic          req_use_imm;
    logic [4:0]    req_imm;
    logic [31:0]   req_rs1_data;
    logic          read_enable;
    logic [AW-1:0] read_addr;
    logic [NW-1:0] read_wid;
    logic [UW-1:0] read_uuid;
    logic [31:0]   read_data;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [NW-1:0] write_wid;
    logic [UW-1:0] write_uuid;
    logic [31:0]   write_data;
    logic          rsp_valid, rsp_ready;
    logic [RB-1:0] rsp_rd;
    logic [NW-1:0] rsp_wid;
    logic [UW-1:0] rsp_uuid;
    logic [31:0]   rsp_data;
    logic          busy;
    logic [1:0]    dbg_state;

    vx_csr_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wid(req_wid), .req_uuid(req_uuid),
        .req_rd(req_rd), .req_use_imm(req_use_imm), .req_imm(req_imm),
        .req_rs1_data(req_rs1_data),
        .read_enable(read_enable), .read_addr(read_addr), .read_wid(read_wid),
        .read_uuid(read_uuid), .read_data(read_data),
        .write_enable(write_enable), .write_addr(write_addr),
        .write_wid(write_wid), .write_uuid(write_uuid), .write_data(write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
        .rsp_wid(rsp_wid), .rsp_uuid(rsp_uuid), .rsp_data(rsp_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- CSR storage (bench side) ----------------
    logic [31:0] mem [0:16383];
    logic        pl_en;
    logic [13:0] pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (write_enable) mem[{write_wid, write_addr}] <= write_data;
    end
    assign read_data = mem[{read_wid, read_addr}];

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] ref_mem [0:16383];
    logic [89:0] exp_wq[$];   // {wid, addr, uuid, data}
    logic [82:0] exp_rq[$];   // {rd, wid, uuid, old}
    logic [11:0] addr_set [5] = '{12'h001, 12'h002, 12'h003, 12'h300, 12'h301};

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Program-order execution of one accepted instruction.
    task automatic model_accept();
        logic [13:0] idx;
        logic [31:0] src, old, nv;
        logic        wr;
        idx = {req_wid, req_addr};
        src = req_use_imm ? {27'd0, req_imm} : req_rs1_data;
        old = ref_mem[idx];
        nv  = old;
        wr  = 1'b0;
        case (req_op)
            2'd0: begin nv = src;        wr = 1'b1;           end
            2'd1: begin nv = old | src;  wr = (src != 32'd0); end
            2'd2: begin nv = old & ~src; wr = (src != 32'd0); end
            default: begin nv = old;     wr = 1'b0;           end
        endcase
        if (wr) begin
            exp_wq.push_back({req_wid, req_addr, req_uuid, nv});
            ref_mem[idx] = nv;
        end
        exp_rq.push_back({req_rd, req_wid, req_uuid, old});
    endtask

    task automatic sb_sample();
        logic [89:0] we;
        logic [82:0] re;
        if (reset) return;
        if (write_enable) begin
            if (exp_wq.size() == 0) begin
                check("wr_unexpected", 128'(write_enable), 128'(0));
            end else begin
                we = exp_wq.pop_front();
                check("wr_port", 128'({write_wid, write_addr, write_uuid, write_data}), 128'(we));
            end
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_rq.size() == 0) begin
                check("rsp_unexpected", 128'(rsp_valid), 128'(0));
            end else begin
                re = exp_rq.pop_front();
                check("rsp_port", 128'({rsp_rd, rsp_wid, rsp_uuid, rsp_data}), 128'(re));
            end
        end
        if (req_valid && req_ready) model_accept();
    endtask

    // ---------------- driver tasks ----------------
    task automatic sb_and_edge();
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        sb_and_edge();
    endtask

    task automatic preload(input logic [1:0] w, input logic [11:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_idx = {w, a}; pl_data = d;
        ref_mem[{w, a}] = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [11:0] a, input logic [1:0] w,
                             input logic use_imm, input logic [4:0] imm,
                             input logic [31:0] rs1, input logic [4:0] rd);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wid = w;
        req_use_imm = use_imm; req_imm = imm; req_rs1_data = rs1; req_rd = rd;
        req_uuid = UW'({$urandom(), $urandom()});
    endtask

    // Present a request and wait (bounded) until it is accepted.
    task automatic issue(input logic [1:0] op, input logic [11:0] a, input logic [1:0] w,
                         input logic use_imm, input logic [4:0] imm,
                         input logic [31:0] rs1, input logic [4:0] rd, output int stalls);
        bit done;
        stalls = 0;
        done = 1'b0;
        drive_req(op, a, w, use_imm, imm, rs1, rd);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
            else stalls++;
            sb_and_edge();
        end
        if (!done) check("issue_timeout", 128'(req_ready), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int stalls;
        int wr_cnt;
        logic [UW-1:0] u0;

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; pl_en = 1'b0;
        pl_idx = '0; pl_data = '0;
        req_op = '0; req_addr = '0; req_wid = '0; req_uuid = '0; req_rd = '0;
        req_use_imm = 1'b0; req_imm = '0; req_rs1_data = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 5; k++)
                preload(2'(w), addr_set[k], $urandom);
        preload(2'd0, 12'h300, 32'h1800);
        preload(2'd1, 12'h300, 32'h5);
        preload(2'd2, 12'h300, 32'h10);
        preload(2'd3, 12'h003, 32'h11);
        preload(2'd3, 12'h001, 32'h2);
        preload(2'd0, 12'h001, 32'h9);
        preload(2'd0, 12'h305, 32'h77);
        preload(2'd0, 12'h306, 32'h0);
        preload(2'd0, 12'h310, 32'h1234);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_write_en", 128'(write_enable), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_dbg_state", 128'(dbg_state), 128'(0));
        sb_and_edge();

        // RW 0x300 src 0x8, old 0x1800
        drive_req(2'd0, 12'h300, 2'd0, 1'b0, 5'd0, 32'h8, 5'd1);
        @(negedge clk);
        check("rw_req_ready", 128'(req_ready), 128'(1));
        check("rw_read_en", 128'(read_enable), 128'(1));
        check("rw_read_addr", 128'(read_addr), 128'(12'h300));
        sb_and_edge();
        req_valid = 1'b0;
        @(negedge clk);
        check("rw_write_en", 128'(write_enable), 128'(1));
        check("rw_write_data", 128'(write_data), 128'(32'h8));
        check("rw_rsp_valid", 128'(rsp_valid), 128'(1));
        check("rw_rsp_data", 128'(rsp_data), 128'(32'h1800));
        check("rw_dbg_state", 128'(dbg_state), 128'(1));
        sb_and_edge();

        // RS imm 0 (read only) then RC src 0x4 on old 0x5
        drive_req(2'd1, 12'h300, 2'd1, 1'b1, 5'd0, 32'hFFFF, 5'd2);
        @(negedge clk);
        check("rs0_req_ready", 128'(req_ready), 128'(1));
        sb_and_edge();
        drive_req(2'd2, 12'h300, 2'd1, 1'b0, 5'd0, 32'h4, 5'd3);
        @(negedge clk);
        check("rs0_no_write", 128'(write_enable), 128'(0));
        check("rs0_rsp_data", 128'(rsp_data), 128'(32'h5));
        check("rc_req_ready", 128'(req_ready), 128'(1));
        sb_and_edge();
        req_valid = 1'b0;
        @(negedge clk);
        check("rc_write_en", 128'(write_enable), 128'(1));
        check("rc_write_data", 128'(write_data), 128'(32'h1));
        check("rc_rsp_data", 128'(rsp_data), 128'(32'h5));
        sb_and_edge();

        // op 3 never writes, returns the old value
        issue(2'd3, 12'h300, 2'd1, 1'b0, 5'd0, 32'hFF, 5'd4, stalls);
        req_valid = 1'b0;
        @(negedge clk);
        check("op3_no_write", 128'(write_enable), 128'(0));
        check("op3_rsp_data", 128'(rsp_data), 128'(32'h1));
        sb_and_edge();

        // Back-to-back RW then RS to the same CSR and warp
        drive_req(2'd0, 12'h300, 2'd2, 1'b0, 5'd0, 32'h3, 5'd5);
        @(negedge clk);
        sb_and_edge();
        issue(2'd1, 12'h300, 2'd2, 1'b0, 5'd0, 32'h40, 5'd6, stalls);
        check("raw_stalls", 128'(stalls), 128'(EXP_RAW_STALL));
        req_valid = 1'b0;
        @(negedge clk);
        check("raw_write_data", 128'(write_data), 128'(32'h43));
        sb_and_edge();
        cyc();

        // fcsr write followed by fflags read: same warp stalls, other warp does not
        drive_req(2'd0, 12'h003, 2'd3, 1'b0, 5'd0, 32'h7, 5'd7);
        @(negedge clk);
        sb_and_edge();
        issue(2'd1, 12'h001, 2'd3, 1'b1, 5'd0, 32'h0, 5'd8, stalls);
        check("alias_stalls", 128'(stalls), 128'(1));
        req_valid = 1'b0;
        cyc(); cyc();
        drive_req(2'd0, 12'h003, 2'd3, 1'b0, 5'd0, 32'h8, 5'd9);
        @(negedge clk);
        sb_and_edge();
        issue(2'd1, 12'h001, 2'd0, 1'b1, 5'd0, 32'h0, 5'd10, stalls);
        check("alias_otherwid_stalls", 128'(stalls), 128'(0));
        req_valid = 1'b0;
        cyc(); cyc();

        // Response backpressure for three cycles
        rsp_ready = 1'b0;
        issue(2'd0, 12'h305, 2'd0, 1'b0, 5'd0, 32'hAB, 5'd11, stalls);
        u0 = req_uuid;
        drive_req(2'd0, 12'h306, 2'd0, 1'b0, 5'd0, 32'h1, 5'd12);
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (write_enable) wr_cnt++;
            check("bp_req_ready", 128'(req_ready), 128'(0));
            check("bp_rsp_valid", 128'(rsp_valid), 128'(1));
            check("bp_rsp_data", 128'(rsp_data), 128'(32'h77));
            check("bp_rsp_rd", 128'(rsp_rd), 128'(5'd11));
            check("bp_rsp_uuid", 128'(rsp_uuid), 128'(u0));
            check("bp_dbg_state", 128'(dbg_state), 128'((i == 0) ? 2'd1 : 2'd2));
            sb_and_edge();
        end
        check("bp_write_count", 128'(wr_cnt), 128'(1));
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 128'(req_ready), 128'(1));
        sb_and_edge();
        req_valid = 1'b0;
        cyc(); cyc();

        // Reset while in WRITE (RW writes back the value already stored)
        drive_req(2'd0, 12'h310, 2'd0, 1'b0, 5'd0, 32'h1234, 5'd13);
        @(negedge clk);
        sb_and_edge();
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        sb_and_edge();
        reset = 1'b0;
        exp_wq.delete();
        exp_rq.delete();
        @(negedge clk);
        check("rstw_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rstw_write_en", 128'(write_enable), 128'(0));
        check("rstw_busy", 128'(busy), 128'(0));
        sb_and_edge();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            req_valid    = ($urandom_range(0, 9) < 7);
            req_op       = 2'($urandom_range(0, 3));
            req_addr     = addr_set[$urandom_range(0, 4)];
            req_wid      = 2'($urandom_range(0, 3));
            req_use_imm  = 1'($urandom_range(0, 1));
            req_imm      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            req_rs1_data = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            req_rd       = 5'($urandom);
            req_uuid     = UW'({$urandom(), $urandom()});
            rsp_ready    = ($urandom_range(0, 3) != 0);
            cyc();
        end

        // Drain and final state comparison
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) cyc();
        check("drain_write_q", 128'(exp_wq.size()), 128'(0));
        check("drain_rsp_q", 128'(exp_rq.size()), 128'(0));
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 5; k++)
                check("final_csr", 128'(mem[{2'(w), addr_set[k]}]), 128'(ref_mem[{2'(w), addr_set[k]}]));
        check("final_csr_305", 128'(mem[{2'd0, 12'h305}]), 128'(ref_mem[{2'd0, 12'h305}]));
        check("final_csr_306", 128'(mem[{2'd0, 12'h306}]), 128'(ref_mem[{2'd0, 12'h306}]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
